brq_muldiv: RTL

BRQ_MULDIV -- requirements
Module: brq_muldiv

---
 rtl/brq_muldiv.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/brq_muldiv.sv
// RV32M multiply/divide unit: iterative shift-add multiply and restoring divide.
// Define BRQ_MD_FASTMUL_EN to replace the iterative multiply with a one-cycle full-width product.
module brq_muldiv #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned RegAddrWidth = 5
) (
    input  logic                    brq_clk,
    input  logic                    brq_rst,
    input  logic                    md_valid_i,
    input  logic [2:0]              md_op_i,
    input  logic [DataWidth-1:0]    md_op_a_i,
    input  logic [DataWidth-1:0]    md_op_b_i,
    input  logic [RegAddrWidth-1:0] md_rd_i,
    input  logic                    md_flush_i,
    output logic                    md_ready_o,
    output logic                    md_busy_o,
    output logic                    md_done_o,
    output logic [DataWidth-1:0]    md_result_o,
    output logic [RegAddrWidth-1:0] md_rd_o
);

    localparam int unsigned CntWidth = $clog2(DataWidth);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(DataWidth - 1);
    localparam logic [DataWidth-1:0] MostNeg = {1'b1, {(DataWidth-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [CntWidth-1:0]     cnt_q, cnt_d;
    logic [2:0]              op_q, op_d;
    logic [DataWidth-1:0]    acc_q, acc_d;
    logic [DataWidth-1:0]    lo_q, lo_d;
    logic [DataWidth-1:0]    opb_q, opb_d;
    logic                    neg_q, neg_d;
    logic                    rem_neg_q, rem_neg_d;
    logic [RegAddrWidth-1:0] rd_q, rd_d;
    logic [RegAddrWidth-1:0] rd_out_q, rd_out_d;
    logic [DataWidth-1:0]    res_q, res_d;

    // Operand decode on the request inputs
    logic                 in_is_div, a_signed, b_signed, a_neg, b_neg;
    logic [DataWidth-1:0] abs_a, abs_b;
    logic                 div_zero, div_ovf;
    logic [DataWidth-1:0] special_res;

    assign in_is_div = md_op_i[2];
    assign a_signed  = in_is_div ? ~md_op_i[0] : (md_op_i[1:0] != 2'b11);
    assign b_signed  = in_is_div ? ~md_op_i[0] : ~md_op_i[1];
    assign a_neg     = a_signed & md_op_a_i[DataWidth-1];
    assign b_neg     = b_signed & md_op_b_i[DataWidth-1];
    assign abs_a     = a_neg ? -md_op_a_i : md_op_a_i;
    assign abs_b     = b_neg ? -md_op_b_i : md_op_b_i;
    assign div_zero  = in_is_div & (md_op_b_i == '0);
    assign div_ovf   = in_is_div & ~md_op_i[0] & (md_op_a_i == MostNeg) & (md_op_b_i == '1);
    // op[1] selects remainder for the divide group
    assign special_res = md_op_i[1] ? (div_zero ? md_op_a_i : '0)
                                    : (div_zero ? '1 : md_op_a_i);

`ifdef BRQ_MD_FASTMUL_EN
    logic [2*DataWidth-1:0] fast_prod;
    assign fast_prod = {{DataWidth{1'b0}}, abs_a} * {{DataWidth{1'b0}}, abs_b};
`endif

    // One iteration of each algorithm
    logic [DataWidth:0] mul_sum, div_shift, div_diff;
    assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {acc_q, lo_q[DataWidth-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};

    // Sign correction and result selection
    logic [2*DataWidth-1:0] prod_abs, prod;
    logic [DataWidth-1:0]   quot, rem, fix_res;
    assign prod_abs = {acc_q, lo_q};
    assign prod     = neg_q ? -prod_abs : prod_abs;
    assign quot     = neg_q ? -lo_q : lo_q;
    assign rem      = rem_neg_q ? -acc_q : acc_q;

    always_comb begin
        fix_res = '0;
        case (op_q)
            3'b000:                 fix_res = prod[DataWidth-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*DataWidth-1:DataWidth];
            3'b100, 3'b101:         fix_res = quot;
            default:                fix_res = rem;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        rd_d      = rd_q;
        rd_out_d  = rd_out_q;
        res_d     = res_q;

        case (state_q)
            IDLE: begin
                if (md_valid_i) begin
                    op_d      = md_op_i;
                    rd_d      = md_rd_i;
                    opb_d     = abs_b;
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    cnt_d     = '0;
                    if (div_zero || div_ovf) begin
                        res_d    = special_res;
                        rd_out_d = md_rd_i;
                        state_d  = DONE;
                    end
`ifdef BRQ_MD_FASTMUL_EN
                    else if (!in_is_div) begin
                        {acc_d, lo_d} = fast_prod;
                        state_d       = FIX;
                    end
`endif
                    else begin
                        acc_d   = '0;
                        lo_d    = abs_a;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (op_q[2]) begin
                    if (!div_diff[DataWidth]) begin
                        acc_d = div_diff[DataWidth-1:0];
                        lo_d  = {lo_q[DataWidth-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift[DataWidth-1:0];
                        lo_d  = {lo_q[DataWidth-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[DataWidth:1];
                    lo_d  = {mul_sum[0], lo_q[DataWidth-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end
            end
            FIX: begin
                res_d    = fix_res;
                rd_out_d = rd_q;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Flush cancels any accept or completion decided above
        if (md_flush_i) begin
            state_d  = IDLE;
            cnt_d    = '0;
            res_d    = res_q;
            rd_out_d = rd_out_q;
        end
    end

    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            lo_q      <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            rd_q      <= '0;
            rd_out_q  <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            lo_q      <= lo_d;
            opb_q     <= opb_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            rd_q      <= rd_d;
            rd_out_q  <= rd_out_d;
            res_q     <= res_d;
        end
    end

    assign md_ready_o  = (state_q == IDLE);
    assign md_busy_o   = (state_q != IDLE);
    assign md_done_o   = (state_q == DONE);
    assign md_result_o = res_q;
    assign md_rd_o     = rd_out_q;

endmodule
